alu_share_arbiter: RTL and testbench

// - Shares one combinational ALU (16-bit, opcode/a/b -> c/flags O|N|C|Z) among NUM_REQ requesters.
// - Arbitrates requests round-robin and drives the latched operands to the ALU.
// - Captures the result and flags, then returns them to the granted requester through a valid/ready handshake.
// - Owns the architectural flags register: flags update only on ALU-class opcodes and hold otherwise.
//

---
 rtl/alu_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/alu_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcode field positions, flag bit positions and FSM encoding
// for the shared-ALU arbiter.
package alu_pkg;

    localparam int         DATA_WIDTH  = 16;
    localparam logic [3:0] ALU_NIBBLE  = 4'h1;

    // Opcode fields: class select and operation.
    localparam int SEL_HI = 15;
    localparam int SEL_LO = 12;
    localparam int OP_HI  = 11;
    localparam int OP_LO  = 8;

    // Flag bit positions inside the {O,N,C,Z} nibble.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 3;

    // Flags come out of reset with only Z set.
    localparam logic [3:0] FLAGS_RESET = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Class-select field of an opcode.
    function automatic logic [3:0] alu_select(input logic [DATA_WIDTH-1:0] opcode);
        return opcode[SEL_HI:SEL_LO];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the first requester at or after the pointer wins,
// wrapping modulo NUM_REQ. The pointer moves past the served requester only
// when the owner of a transaction finishes.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    input  logic [IDX_W-1:0]   adv_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] scan_idx;

    // Next pointer: one past the requester whose transaction just completed.
    always_comb begin
        // NOTE: every signal driven here gets a value before any branch, so no latch can be inferred.
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = (adv_idx == IDX_W'(NUM_REQ - 1)) ? '0 : adv_idx + IDX_W'(1);
        end
    end

    // Scan from the farthest offset back to offset 0 so the nearest valid requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        scan_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (req[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters. A round-robin grant
// latches one request, the ALU result is captured in EXEC, and the response
// is held for the owner in RESP until it accepts. The block also owns the
// architectural flags register, which only ALU-class opcodes update.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter int         DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter logic [3:0] ALU_NIBBLE = alu_pkg::ALU_NIBBLE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opcode,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [3:0]                    rsp_flags,
    output logic [DATA_WIDTH-1:0]         alu_opcode,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    input  logic [DATA_WIDTH-1:0]         alu_c,
    input  logic [3:0]                    alu_flags,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]            flags_q, flags_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  adv;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .reset       (reset),
        .req         (req_valid),
        .adv         (adv),
        .adv_idx     (owner_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // FSM next state, operand/result latches, flags register and response valid.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_data_d  = rsp_data_q;
        flags_d     = flags_q;
        rsp_valid_d = rsp_valid_q;
        adv         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d  = grant_idx;
                    opcode_d = req_opcode[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    a_d      = req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    b_d      = req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_c;
                if (alu_select(opcode_q) == ALU_NIBBLE) begin
                    flags_d = alu_flags;
                end
                rsp_valid_d          = '0;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = ST_RESP;
            end
            ST_RESP: begin
                // Only the owner's accept counts; other rsp_ready bits are ignored.
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    adv         = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The ALU sees the latched operation only during EXEC and a non-ALU opcode otherwise.
    always_comb begin
        alu_opcode = '0;
        alu_a      = '0;
        alu_b      = '0;
        if (state_q == ST_EXEC) begin
            alu_opcode = opcode_q;
            alu_a      = a_q;
            alu_b      = b_q;
        end
    end

    // The accept pulse is the IDLE-cycle grant itself, so the requester sees it
    // in the cycle its operands are latched; no grant while a response is pending.
    assign req_ready = (state_q == ST_IDLE) ? grant : '0;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = flags_q;

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            opcode_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            flags_q     <= FLAGS_RESET;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_data_q  <= rsp_data_d;
            flags_q     <= flags_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU standing in
// for the shared combinational unit.
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_opcode = '0;
    logic [NREQ*DW-1:0] req_a = '0;
    logic [NREQ*DW-1:0] req_b = '0;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready = '0;
    logic [DW-1:0]      rsp_data;
    logic [3:0]         rsp_flags;
    logic [DW-1:0]      alu_opcode, alu_a, alu_b, alu_c;
    logic [3:0]         alu_flags;
    logic               busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    alu_share_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_flags  (alu_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: class 1 does add/sub/and with {O,N,C,Z}; any other
    // class returns 0 with all flags set, so a wrong flag capture is visible.
    logic [16:0] alu_wide;
    always_comb begin
        alu_wide  = '0;
        alu_c     = '0;
        alu_flags = 4'b1111;
        if (alu_opcode[15:12] == 4'h1) begin
            alu_flags = 4'b0000;
            case (alu_opcode[11:8])
                4'h0: begin
                    alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
                    alu_flags[3] = (alu_a[15] == alu_b[15]) && (alu_wide[15] != alu_a[15]);
                end
                4'h1: begin
                    alu_wide     = {1'b0, alu_a} - {1'b0, alu_b};
                    alu_flags[3] = (alu_a[15] != alu_b[15]) && (alu_wide[15] != alu_a[15]);
                end
                default: alu_wide = {1'b0, alu_a & alu_b};
            endcase
            alu_c        = alu_wide[15:0];
            alu_flags[2] = alu_wide[15];
            alu_flags[1] = alu_wide[16];
            alu_flags[0] = (alu_wide[15:0] == 16'h0000);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_valid = '0; rsp_ready = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drives one request from requester k, waits (bounded) for accept and
    // response, then accepts the response. Returns latency accept->rsp_valid.
    task automatic run_one(input int k, input logic [15:0] op, input logic [15:0] a,
                           input logic [15:0] b, output bit ok, output int lat,
                           output logic [15:0] d, output logic [3:0] f);
        int t;
        int n;
        ok = 1'b0; lat = -1; d = '0; f = '0;
        @(posedge clk); #1;
        req_opcode[k*DW +: DW] = op;
        req_a[k*DW +: DW]      = a;
        req_b[k*DW +: DW]      = b;
        req_valid[k]           = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready[k] && t < 20) begin @(negedge clk); t++; end
        if (!req_ready[k]) begin req_valid[k] = 1'b0; return; end
        n = cyc;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        t = 0;
        @(negedge clk);
        while (!rsp_valid[k] && t < 20) begin @(negedge clk); t++; end
        if (!rsp_valid[k]) return;
        lat = cyc - n;
        d = rsp_data;
        f = rsp_flags;
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_total++; if (req_ready !== 4'b0000) $display("FAIL rst_req_ready: got %b expected 0000", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL rst_rsp_valid: got %b expected 0000", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 16'h0000) $display("FAIL rst_rsp_data: got %h expected 0000", rsp_data); else n_pass++;
        n_total++; if (rsp_flags !== 4'b0001) $display("FAIL rst_flags: got %b expected 0001", rsp_flags); else n_pass++;
        n_total++; if ({alu_opcode, alu_a, alu_b} !== 48'h0) $display("FAIL rst_alu: got %h expected 0", {alu_opcode, alu_a, alu_b}); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_add();
        bit ok; int lat; logic [15:0] d; logic [3:0] f;
        run_one(0, 16'h1000, 16'd3, 16'd4, ok, lat, d, f);
        n_total++; if (ok !== 1'b1) $display("FAIL add_handshake: got timeout expected completion"); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL add_latency: got %0d expected 2", lat); else n_pass++;
        n_total++; if (d !== 16'h0007) $display("FAIL add_data: got %h expected 0007", d); else n_pass++;
        n_total++; if (f !== 4'b0000) $display("FAIL add_flags: got %b expected 0000", f); else n_pass++;
    endtask

    task automatic test_sub_zero();
        bit ok; int lat; logic [15:0] d; logic [3:0] f;
        run_one(1, 16'h1100, 16'd5, 16'd5, ok, lat, d, f);
        n_total++; if (ok !== 1'b1) $display("FAIL sub_handshake: got timeout expected completion"); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL sub_latency: got %0d expected 2", lat); else n_pass++;
        n_total++; if (d !== 16'h0000) $display("FAIL sub_data: got %h expected 0000", d); else n_pass++;
        n_total++; if (f !== 4'b0001) $display("FAIL sub_flags: got %b expected 0001", f); else n_pass++;
    endtask

    task automatic test_flags_hold();
        bit ok; int lat; logic [15:0] d; logic [3:0] f;
        run_one(0, 16'h1000, 16'h7FFF, 16'h0001, ok, lat, d, f);
        n_total++; if (ok !== 1'b1) $display("FAIL ovf_handshake: got timeout expected completion"); else n_pass++;
        n_total++; if (d !== 16'h8000) $display("FAIL ovf_data: got %h expected 8000", d); else n_pass++;
        n_total++; if (f !== 4'b1100) $display("FAIL ovf_flags: got %b expected 1100", f); else n_pass++;
        run_one(0, 16'h2000, 16'h0005, 16'h0006, ok, lat, d, f);
        n_total++; if (ok !== 1'b1) $display("FAIL nonalu_handshake: got timeout expected completion"); else n_pass++;
        n_total++; if (d !== 16'h0000) $display("FAIL nonalu_data: got %h expected 0000", d); else n_pass++;
        n_total++; if (f !== 4'b1100) $display("FAIL nonalu_flags_hold: got %b expected 1100", f); else n_pass++;
        @(negedge clk);
        n_total++; if (rsp_flags !== 4'b1100) $display("FAIL idle_flags: got %b expected 1100", rsp_flags); else n_pass++;
    endtask

    task automatic test_round_robin();
        int g[$];
        int gc[$];
        int r[$];
        logic [15:0] rd[$];
        int t;
        int exp_order [6];
        logic [15:0] exp_data [4];
        exp_order = '{0, 1, 2, 3, 0, 1};
        exp_data  = '{16'h0011, 16'h0121, 16'h0231, 16'h0341};
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            req_opcode[k*DW +: DW] = 16'h1000;
            req_a[k*DW +: DW]      = 16'((k << 8) + 1);
            req_b[k*DW +: DW]      = 16'((k + 1) << 4);
        end
        rsp_ready = '1;
        req_valid = '1;
        t = 0;
        while (r.size() < 6 && t < 60) begin
            @(negedge clk); t++;
            for (int k = 0; k < NREQ; k++) begin
                if (req_ready[k]) begin g.push_back(k); gc.push_back(cyc); end
                if (rsp_valid[k]) begin r.push_back(k); rd.push_back(rsp_data); end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '0;
        n_total++; if (r.size() !== 6) $display("FAIL rr_rsp_count: got %0d expected 6", r.size()); else n_pass++;
        n_total++; if (g.size() !== 6) $display("FAIL rr_grant_count: got %0d expected 6", g.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i < g.size()) begin
                n_total++; if (g[i] !== exp_order[i]) $display("FAIL rr_grant_%0d: got %0d expected %0d", i, g[i], exp_order[i]); else n_pass++;
            end
            if (i < r.size()) begin
                n_total++; if (r[i] !== exp_order[i]) $display("FAIL rr_owner_%0d: got %0d expected %0d", i, r[i], exp_order[i]); else n_pass++;
                n_total++; if (rd[i] !== exp_data[exp_order[i]]) $display("FAIL rr_data_%0d: got %h expected %h", i, rd[i], exp_data[exp_order[i]]); else n_pass++;
            end
        end
        if (gc.size() >= 6) begin
            n_total++; if (gc[5] - gc[0] !== 15) $display("FAIL rr_throughput: got %0d cycles expected 15", gc[5] - gc[0]); else n_pass++;
        end
    endtask

    task automatic test_stall();
        int t;
        @(posedge clk); #1;
        rsp_ready = '0;
        req_opcode[2*DW +: DW] = 16'h1000; req_a[2*DW +: DW] = 16'h0100; req_b[2*DW +: DW] = 16'h0023;
        req_opcode[0*DW +: DW] = 16'h1100; req_a[0*DW +: DW] = 16'h0009; req_b[0*DW +: DW] = 16'h0009;
        req_valid = 4'b0101;
        @(negedge clk);
        n_total++; if (req_ready !== 4'b0100) $display("FAIL stall_first_grant: got %b expected 0100", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        t = 0;
        @(negedge clk);
        while (!rsp_valid[2] && t < 20) begin @(negedge clk); t++; end
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (rsp_valid !== 4'b0100) $display("FAIL stall_valid_%0d: got %b expected 0100", i, rsp_valid); else n_pass++;
            n_total++; if (rsp_data !== 16'h0123) $display("FAIL stall_data_%0d: got %h expected 0123", i, rsp_data); else n_pass++;
            n_total++; if (rsp_flags !== 4'b0000) $display("FAIL stall_flags_%0d: got %b expected 0000", i, rsp_flags); else n_pass++;
            n_total++; if (req_ready !== 4'b0000) $display("FAIL stall_req_ready_%0d: got %b expected 0000", i, req_ready); else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 4'b0100;
        @(posedge clk); #1;
        rsp_ready = '0;
        t = 0;
        @(negedge clk);
        while (!req_ready[0] && t < 20) begin @(negedge clk); t++; end
        n_total++; if (req_ready !== 4'b0001) $display("FAIL stall_release_grant: got %b expected 0001", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        t = 0;
        @(negedge clk);
        while (!rsp_valid[0] && t < 20) begin @(negedge clk); t++; end
        n_total++; if (rsp_valid !== 4'b0001) $display("FAIL stall_req0_valid: got %b expected 0001", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 16'h0000) $display("FAIL stall_req0_data: got %h expected 0000", rsp_data); else n_pass++;
        n_total++; if (rsp_flags !== 4'b0001) $display("FAIL stall_req0_flags: got %b expected 0001", rsp_flags); else n_pass++;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        bit ok; int lat; logic [15:0] d; logic [3:0] f;
        int t;
        run_one(1, 16'h1000, 16'hC000, 16'h4001, ok, lat, d, f);
        n_total++; if (d !== 16'h0001) $display("FAIL pre_rst_data: got %h expected 0001", d); else n_pass++;
        n_total++; if (f !== 4'b0010) $display("FAIL pre_rst_flags: got %b expected 0010", f); else n_pass++;
        @(posedge clk); #1;
        req_opcode[3*DW +: DW] = 16'h1000; req_a[3*DW +: DW] = 16'h8000; req_b[3*DW +: DW] = 16'h8000;
        req_valid[3] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready[3] && t < 20) begin @(negedge clk); t++; end
        n_total++; if (req_ready !== 4'b1000) $display("FAIL mid_grant3: got %b expected 1000", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL mid_exec_busy: got %b expected 1", busy); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL mid_rsp_valid: got %b expected 0000", rsp_valid); else n_pass++;
        n_total++; if (rsp_flags !== 4'b0001) $display("FAIL mid_flags: got %b expected 0001", rsp_flags); else n_pass++;
        n_total++; if (rsp_data !== 16'h0000) $display("FAIL mid_data: got %h expected 0000", rsp_data); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (rsp_valid !== 4'b0000) $display("FAIL mid_dropped_%0d: got %b expected 0000", i, rsp_valid); else n_pass++;
        end
        @(posedge clk); #1;
        req_opcode[1*DW +: DW] = 16'h1000;
        req_valid = 4'b1010;
        @(negedge clk);
        n_total++; if (req_ready !== 4'b0010) $display("FAIL mid_ptr_reset_grant: got %b expected 0010", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_flags_hold();
        test_round_robin();
        test_stall();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
